// File: rtl/hazard_scoreboard.sv
// Register-file hazard scoreboard: per-register in-flight write counters drive
// RAW/full stalls, pending flags, a saturating stall counter and an underflow flag.
module hazard_scoreboard #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic                   id_use1,
    input  logic                   id_use2,
    input  logic [1:0]             id_addr1,
    input  logic [1:0]             id_addr2,
    input  logic                   id_writes,
    input  logic [1:0]             id_addr3,
    input  logic                   id_flush,
    input  logic                   wb_write,
    input  logic [1:0]             wb_addr3,
    output logic                   stall,
    output logic                   issue,
    output logic [3:0]             pending,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   err_underflow
);

    logic [1:0]             cnt_q [4];
    logic [1:0]             cnt_d [4];
    logic [STALL_CNT_W-1:0] stall_count_q;
    logic                   err_q;
    logic                   err_d;
    logic                   inc;
    logic                   raw_hit;
    logic                   full_hit;

    // Hazards are judged on registered counts only, so a same-cycle retire
    // releases the stall one cycle later.
    always_comb begin
        raw_hit  = (id_use1 && (cnt_q[id_addr1] != 2'd0)) ||
                   (id_use2 && (cnt_q[id_addr2] != 2'd0));
        full_hit = id_writes && (cnt_q[id_addr3] == 2'd3);
        stall    = id_valid && !id_flush && (raw_hit || full_hit);
        issue    = id_valid && !id_flush && !stall;
        inc      = issue && id_writes;
    end

    always_comb begin
        err_d = err_q;
        for (int r = 0; r < 4; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc && (id_addr3 == 2'(r)) && wb_write && (wb_addr3 == 2'(r))) begin
                cnt_d[r] = cnt_q[r];
            end else if (inc && (id_addr3 == 2'(r))) begin
                cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (wb_write && (wb_addr3 == 2'(r))) begin
                if (cnt_q[r] != 2'd0) begin
                    cnt_d[r] = cnt_q[r] - 2'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 4; r++) begin
                cnt_q[r] <= 2'd0;
            end
            stall_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (stall && !(&stall_count_q)) begin
                stall_count_q <= stall_count_q + STALL_CNT_W'(1);
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            pending[r] = (cnt_q[r] != 2'd0);
        end
    end

    assign stall_count   = stall_count_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: driver pushes reference-model expectations each cycle,
// an independent monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic       u1;
        logic [1:0] a1;
        logic       u2;
        logic [1:0] a2;
        logic       w;
        logic [1:0] a3;
        logic       fl;
        logic       wb;
        logic [1:0] wba;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic [3:0]  pending;
        logic [15:0] sc16;
        logic [3:0]  sc4;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_use1, id_use2, id_writes, id_flush, wb_write;
    logic [1:0]  id_addr1, id_addr2, id_addr3, wb_addr3;
    logic        stall, issue, err_underflow;
    logic [3:0]  pending;
    logic [15:0] stall_count;
    logic        stall_4, issue_4, err_4;
    logic [3:0]  pending_4;
    logic [3:0]  stall_count_4;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Reference model: list of destination registers with writes in flight.
    int    inflight[$];
    int    stalls;
    bit    err_m;
    stim_t cur;
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_use1(id_use1),
        .id_use2(id_use2), .id_addr1(id_addr1), .id_addr2(id_addr2),
        .id_writes(id_writes), .id_addr3(id_addr3), .id_flush(id_flush),
        .wb_write(wb_write), .wb_addr3(wb_addr3), .stall(stall), .issue(issue),
        .pending(pending), .stall_count(stall_count), .err_underflow(err_underflow)
    );

    hazard_scoreboard #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_use1(id_use1),
        .id_use2(id_use2), .id_addr1(id_addr1), .id_addr2(id_addr2),
        .id_writes(id_writes), .id_addr3(id_addr3), .id_flush(id_flush),
        .wb_write(wb_write), .wb_addr3(wb_addr3), .stall(stall_4), .issue(issue_4),
        .pending(pending_4), .stall_count(stall_count_4), .err_underflow(err_4)
    );

    task automatic cmp(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int count_of(input int r);
        int n = 0;
        foreach (inflight[i]) if (inflight[i] == r) n++;
        return n;
    endfunction

    function automatic bit model_stall(input stim_t s);
        if (!s.v || s.fl) return 1'b0;
        if (s.u1 && count_of(int'(s.a1)) > 0) return 1'b1;
        if (s.u2 && count_of(int'(s.a2)) > 0) return 1'b1;
        if (s.w && count_of(int'(s.a3)) == 3) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_issue(input stim_t s);
        return s.v && !s.fl && !model_stall(s);
    endfunction

    function automatic void model_clear();
        inflight.delete();
        stalls = 0;
        err_m  = 1'b0;
    endfunction

    function automatic void model_edge(input stim_t s);
        bit st, inc;
        int idx;
        if (!s.rst) begin
            model_clear();
            return;
        end
        st  = model_stall(s);
        inc = model_issue(s) && s.w;
        if (!(inc && s.wb && s.a3 == s.wba)) begin
            if (s.wb) begin
                idx = -1;
                foreach (inflight[i]) if (idx < 0 && inflight[i] == int'(s.wba)) idx = i;
                if (idx >= 0) inflight.delete(idx);
                else err_m = 1'b1;
            end
            if (inc) inflight.push_back(int'(s.a3));
        end
        if (st) stalls++;
    endfunction

    function automatic exp_t model_expect(input stim_t s);
        exp_t e;
        e.stall = model_stall(s);
        e.issue = model_issue(s);
        for (int r = 0; r < 4; r++) e.pending[r] = (count_of(r) > 0);
        e.sc16 = (stalls > 65535) ? 16'hffff : 16'(stalls);
        e.sc4  = (stalls > 15) ? 4'hf : 4'(stalls);
        e.err  = err_m;
        return e;
    endfunction

    function automatic stim_t mk(input int v, input int u1, input int a1, input int u2,
                                 input int a2, input int w, input int a3, input int fl,
                                 input int wb, input int wba);
        stim_t s;
        s.rst = 1'b1;  s.v = 1'(v);   s.u1 = 1'(u1); s.a1 = 2'(a1);
        s.u2 = 1'(u2); s.a2 = 2'(a2); s.w = 1'(w);   s.a3 = 2'(a3);
        s.fl = 1'(fl); s.wb = 1'(wb); s.wba = 2'(wba);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset_n = s.rst;  id_valid = s.v;  id_use1 = s.u1; id_addr1 = s.a1;
        id_use2 = s.u2;   id_addr2 = s.a2; id_writes = s.w; id_addr3 = s.a3;
        id_flush = s.fl;  wb_write = s.wb; wb_addr3 = s.wba;
    endtask

    // One cycle: model absorbs the edge, new inputs go out 2 units later,
    // expectation is queued; returns 3 units after the edge with outputs settled.
    task automatic tick(input stim_t s);
        @(posedge clk);
        model_edge(cur);
        #2;
        cur = s;
        apply(s);
        if (!s.rst) model_clear();
        exp_q.push_back(model_expect(s));
        mon_en = 1'b1;
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #7;
            if (mon_en) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL queue: got empty expected entry at %0t", $time);
                end else begin
                    n_cmp--;
                    e = exp_q.pop_front();
                    cmp("stall", int'(stall), int'(e.stall));
                    cmp("issue", int'(issue), int'(e.issue));
                    cmp("pending", int'(pending), int'(e.pending));
                    cmp("stall_count", int'(stall_count), int'(e.sc16));
                    cmp("stall_count_w4", int'(stall_count_4), int'(e.sc4));
                    cmp("err_underflow", int'(err_underflow), int'(e.err));
                end
            end
        end
    end

    initial begin : driver
        stim_t idle, s;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        cur = idle;
        cur.rst = 1'b0;
        apply(cur);
        #1;
        cmp("reset_pending", int'(pending), 0);
        cmp("reset_stall_count", int'(stall_count), 0);
        cmp("reset_err", int'(err_underflow), 0);
        tick(cur);
        tick(cur);
        tick(idle);

        // RAW on r1
        tick(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tick(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cmp("raw_stall", int'(stall), 1);
        cmp("raw_pending", int'(pending), 4'b0010);
        tick(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tick(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1));
        cmp("raw_same_cycle_retire_stall", int'(stall), 1);
        tick(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        cmp("raw_release_issue", int'(issue), 1);
        tick(idle);
        cmp("raw_stall_count", int'(stall_count), 3);

        // full counter on r2
        repeat (3) tick(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        tick(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        cmp("full_stall", int'(stall), 1);
        cmp("full_pending", int'(pending), 4'b0100);
        tick(mk(1, 0, 0, 0, 0, 1, 2, 0, 1, 2));
        tick(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        cmp("full_issue_after_retire", int'(issue), 1);
        tick(idle);
        repeat (3) tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2));

        // simultaneous issue-write and retire of r3
        tick(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0));
        tick(mk(1, 0, 0, 0, 0, 1, 3, 0, 1, 3));
        tick(idle);
        cmp("simul_pending", int'(pending), 4'b1000);
        tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3));

        // flush of a dependent instruction
        tick(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tick(mk(1, 1, 0, 1, 0, 1, 0, 1, 0, 0));
        cmp("flush_stall", int'(stall), 0);
        cmp("flush_issue", int'(issue), 0);
        tick(idle);
        cmp("flush_pending", int'(pending), 4'b0001);

        // asynchronous reset mid-operation
        tick(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tick(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0));
        tick(idle);
        cmp("prereset_pending", int'(pending), 4'b1011);
        s = idle;
        s.rst = 1'b0;
        tick(s);
        cmp("async_reset_pending", int'(pending), 0);
        cmp("async_reset_stall_count", int'(stall_count), 0);
        tick(idle);

        // underflow is sticky
        tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tick(idle);
        cmp("underflow_set", int'(err_underflow), 1);
        tick(idle);
        tick(idle);
        cmp("underflow_sticky", int'(err_underflow), 1);

        // stall counter saturation on the narrow instance
        tick(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        repeat (20) tick(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tick(idle);
        cmp("sat_w4", int'(stall_count_4), 15);
        cmp("sat_w16", int'(stall_count), 20);
        tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            s = mk(($urandom_range(9) < 7) ? 1 : 0, $urandom_range(1), $urandom_range(3),
                   $urandom_range(1), $urandom_range(3), $urandom_range(1),
                   $urandom_range(3), ($urandom_range(9) == 0) ? 1 : 0,
                   ($urandom_range(9) < 4) ? 1 : 0, $urandom_range(3));
            if (inflight.size() > 0 && $urandom_range(9) != 0)
                s.wba = 2'(inflight[$urandom_range(inflight.size() - 1)]);
            if ($urandom_range(199) == 0) s.rst = 1'b0;
            tick(s);
        end
        tick(idle);

        #5;
        cmp("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the stall performance counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port id_valid  input  1  a decoded instruction is present in ID.
REQ-005 SHALL have port id_use1, id_use2  input  1 each  instruction reads addr1 / addr2.
REQ-006 SHALL have port id_addr1, id_addr2  input  2 each  RF source addresses.
REQ-007 SHALL have port id_writes  input  1  instruction will write the RF.
REQ-008 SHALL have port id_addr3  input  2  RF destination address.
REQ-009 SHALL have port id_flush  input  1  squash the instruction in ID (not issued).
REQ-010 SHALL have port wb_write  input  1  WB writes RF this cycle (drives RF write enable).
REQ-011 SHALL have port wb_addr3  input  2  WB destination address.
REQ-012 SHALL have port stall  output  1  hold ID/IF this cycle.
REQ-013 SHALL have port issue  output  1  ID instruction advances to EX this cycle.
REQ-014 SHALL have port pending  output  4  bit r set when register r has >=1 in-flight write.
REQ-015 SHALL have port stall_count  output  STALL_CNT_W  saturating count of stall cycles.
REQ-016 SHALL have port err_underflow  output  1  sticky: retire seen with zero in-flight count.

Function
REQ-017 SHALL keep one 2-bit in-flight counter per register (4 counters, max value 3).
REQ-018 SHALL assert stall combinationally when id_valid=1, id_flush=0 and any of: (id_use1 and cnt[id_addr1]!=0), (id_use2 and cnt[id_addr2]!=0), (id_writes and cnt[id_addr3]==3).
REQ-019 SHALL use registered counter values for REQ-018; a retire in the same cycle does not release the stall until the next cycle.
REQ-020 SHALL assert issue = id_valid & ~id_flush & ~stall.
REQ-021 SHALL force stall=0 and issue=0 when id_flush=1.
REQ-022 SHALL increment cnt[id_addr3] on a clock edge where issue=1 and id_writes=1.
REQ-023 SHALL decrement cnt[wb_addr3] on a clock edge where wb_write=1 and its count is nonzero.
REQ-024 SHALL leave the counter unchanged when increment and decrement target the same register in the same cycle.
REQ-025 SHALL, on wb_write=1 with cnt[wb_addr3]==0 and no simultaneous increment of that register, hold the count at 0 and set err_underflow until reset.
REQ-026 SHALL never increment a counter past 3 (guaranteed by REQ-018 stall on full).
REQ-027 SHALL drive pending[r] = (cnt[r]!=0) from registered state.
REQ-028 SHALL increment stall_count by 1 on each edge where stall=1, saturating at all-ones.
REQ-029 SHALL treat id_addr1/id_addr2 with id_use=0 as don't-care (no stall contribution).

Reset
REQ-030 SHALL, while reset_n=0, asynchronously clear all counters, pending=0, stall_count=0, err_underflow=0.
REQ-031 SHALL, on reset assertion mid-operation, discard all in-flight tracking; outputs stall/issue then follow REQ-018..020 with zero counters.
REQ-032 SHALL resume counting on the first rising edge after reset_n deasserts.

Verification
REQ-033 SHALL test RAW: issue write r1, next cycle ID reads r1 -> stall=1, pending=4'b0010 until wb_write r1; stall=0 the cycle after retire, stall_count=number of stall cycles.
REQ-034 SHALL test full: three issued writes to r2 without retire, fourth write to r2 -> stall=1; one retire r2 -> issue=1 next cycle, cnt stays 3.
REQ-035 SHALL test simultaneous issue-write r3 and wb_write r3 with cnt=1 -> cnt remains 1, pending[3]=1.
REQ-036 SHALL test flush: dependent instruction in ID with id_flush=1 -> stall=0, issue=0, counters unchanged.
REQ-037 SHALL test underflow: wb_write r0 with cnt=0 -> err_underflow=1 and stays 1; stall_count saturation with STALL_CNT_W=4 -> holds 15.
REQ-038 SHALL test reset_n pulsed low mid-operation with pending=4'b1011 -> pending=0, stall_count=0 immediately, without a clock edge.
